// File: rtl/fwd_hazard_unit.sv
// EX-stage operand bypass and hazard detection, with a pending-write scoreboard
// for long-latency ops and a saturating stall-cycle counter.
module fwd_hazard_unit #(
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 5,
  parameter int unsigned NRD = 2,
  parameter int unsigned SCW = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                mem_we,
  input  logic                mem_is_ld,
  input  logic [AW-1:0]       mem_wa,
  input  logic [DW-1:0]       mem_wd,
  input  logic                wb_we,
  input  logic [AW-1:0]       wb_wa,
  input  logic [DW-1:0]       wb_wd,
  input  logic [NRD*AW-1:0]   ex_ra,
  input  logic                lo_issue,
  input  logic [AW-1:0]       lo_iwa,
  input  logic                lo_done,
  input  logic [AW-1:0]       lo_dwa,
  input  logic [DW-1:0]       lo_dwd,
  output logic [NRD-1:0]      ex_fe,
  output logic [NRD*DW-1:0]   ex_fd,
  output logic                stall_ex,
  output logic [(2**AW)-1:0]  pend,
  output logic [SCW-1:0]      stall_cnt
);

  localparam int unsigned NREG = 2**AW;

  logic [NRD-1:0]  port_haz;
  logic [AW-1:0]   rd_addr;
  logic            waw_haz;
  logic [NREG-1:0] pend_nxt;

  // Per-port forwarding with fixed priority: long-op done, MEM ALU, MEM load, scoreboard, WB.
  always_comb begin
    ex_fe    = '0;
    ex_fd    = '0;
    port_haz = '0;
    rd_addr  = '0;
    for (int i = 0; i < int'(NRD); i++) begin
      rd_addr = ex_ra[i*AW +: AW];
      if (rd_addr != '0) begin
        if (lo_done && (lo_dwa == rd_addr)) begin
          ex_fe[i]           = 1'b1;
          ex_fd[i*DW +: DW]  = lo_dwd;
        end else if (mem_we && (mem_wa == rd_addr) && !mem_is_ld) begin
          ex_fe[i]           = 1'b1;
          ex_fd[i*DW +: DW]  = mem_wd;
        end else if (mem_we && (mem_wa == rd_addr)) begin
          port_haz[i] = 1'b1;
        end else if (pend[rd_addr]) begin
          port_haz[i] = 1'b1;
        end else if (wb_we && (wb_wa == rd_addr)) begin
          ex_fe[i]           = 1'b1;
          ex_fd[i*DW +: DW]  = wb_wd;
        end
      end
    end
  end

  // A second long op to a still-pending destination must wait unless the first completes now.
  always_comb begin
    waw_haz  = lo_issue && (lo_iwa != '0) && pend[lo_iwa] &&
               !(lo_done && (lo_dwa == lo_iwa));
    stall_ex = (|port_haz) || waw_haz;
  end

  // Scoreboard next state; a same-cycle issue overrides the completion clear.
  always_comb begin
    pend_nxt = pend;
    for (int r = 1; r < int'(NREG); r++) begin
      if (lo_issue && !stall_ex && (lo_iwa == AW'(r))) begin
        pend_nxt[r] = 1'b1;
      end else if (lo_done && (lo_dwa == AW'(r))) begin
        pend_nxt[r] = 1'b0;
      end
    end
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (stall_ex && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + SCW'(1);
    end
  end

endmodule
